grf_write_arbiter: RTL and testbench

GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

---
 rtl/grf_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_grf_write_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/grf_write_arbiter.sv
// Merges WB-stage and long-latency aux writes onto one GRF write port. Grants are combinational, and an aux entry becomes eligible the cycle after its push.
// aux_ready drops while the 2-entry queue is full; a head starved STARVE_LIMIT cycles forces a one-cycle stall_wb.
module grf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        aux_valid,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_data,
    output logic        stall_wb,
    output logic [1:0]  pending_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } aux_ent_t;

    localparam logic [3:0] WAIT_MAX = 4'(STARVE_LIMIT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       stall_q, stall_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    aux_ent_t   mem_q [0:1];
    aux_ent_t   mem_d [0:1];

    logic       head_vld;
    logic       head_gnt;
    logic       wb_gnt;
    logic       push;
    logic       pop;
    aux_ent_t   head;

    assign aux_ready   = (cnt_q != 2'd2);
    assign stall_wb    = stall_q;
    assign pending_cnt = cnt_q;
    assign head_vld    = (cnt_q != 2'd0);
    assign head        = mem_q[rd_ptr_q];
    assign push        = aux_valid & aux_ready;
    assign pop         = head_gnt;

    // Grant is gated by reset so a held WB request cannot write while reset is low.
    always_comb begin
        head_gnt = 1'b0;
        wb_gnt   = 1'b0;
        if (reset) begin
            if (stall_q && head_vld) begin
                head_gnt = 1'b1;
            end else if (!stall_q && wb_we && (wb_addr != 5'd0)) begin
                wb_gnt = 1'b1;
            end else if (head_vld) begin
                head_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        grf_we   = 1'b0;
        grf_addr = 5'd0;
        grf_data = 32'd0;
        if (head_gnt) begin
            grf_we   = (head.addr != 5'd0);
            grf_addr = head.addr;
            grf_data = head.data;
        end else if (wb_gnt) begin
            grf_we   = 1'b1;
            grf_addr = wb_addr;
            grf_data = wb_data;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: aux_addr, data: aux_data};
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 4'd0;
                if (push) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pop) begin
                    wait_cnt_d = 4'd0;
                    state_d    = (cnt_d == 2'd0) ? S_IDLE : S_WAIT;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    wait_cnt_d = 4'd0;
                    state_d    = S_STALL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_STALL: begin
                // The head is always granted here, so the queue shrinks or holds.
                wait_cnt_d = 4'd0;
                state_d    = (cnt_d == 2'd0) ? S_IDLE : S_WAIT;
            end
            default: begin
                wait_cnt_d = 4'd0;
                state_d    = S_IDLE;
            end
        endcase
        stall_d = (state_d == S_STALL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            stall_q    <= 1'b0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed scenarios plus random traffic for grf_write_arbiter, checked against a queue-based model.
module tb_grf_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic        stall_wb;
    logic [1:0]  pending_cnt;

    grf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .aux_valid   (aux_valid),
        .aux_addr    (aux_addr),
        .aux_data    (aux_data),
        .aux_ready   (aux_ready),
        .grf_we      (grf_we),
        .grf_addr    (grf_addr),
        .grf_data    (grf_data),
        .stall_wb    (stall_wb),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_stall;
    int   m_waits;
    bit   m_gh;
    bit   m_gw;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stall = 1'b0;
        m_waits = 0;
    endtask

    // Expected outputs for the current inputs, from the queue contents and stall flag.
    task automatic check_model();
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        m_gh = 1'b0;
        m_gw = 1'b0;
        if (m_stall && q.size() > 0)            m_gh = 1'b1;
        else if (wb_we && wb_addr != 5'd0)      m_gw = 1'b1;
        else if (q.size() > 0)                  m_gh = 1'b1;
        e_we = 1'b0; e_a = 5'd0; e_d = 32'd0;
        if (m_gh) begin
            e_we = (q[0].a != 5'd0); e_a = q[0].a; e_d = q[0].d;
        end else if (m_gw) begin
            e_we = 1'b1; e_a = wb_addr; e_d = wb_data;
        end
        chk("grf_we",      {31'd0, grf_we},    {31'd0, e_we});
        chk("grf_addr",    {27'd0, grf_addr},  {27'd0, e_a});
        chk("grf_data",    grf_data,           e_d);
        chk("aux_ready",   {31'd0, aux_ready}, {31'd0, (q.size() < 2)});
        chk("stall_wb",    {31'd0, stall_wb},  {31'd0, m_stall});
        chk("pending_cnt", {30'd0, pending_cnt}, 32'(q.size()));
    endtask

    task automatic model_step();
        bit acc;
        bit hv;
        bit ns;
        acc = aux_valid && (q.size() < 2);
        hv  = (q.size() > 0);
        ns  = 1'b0;
        if (m_gh) begin
            q.delete(0);
            m_waits = 0;
        end else if (hv) begin
            m_waits++;
            if (m_waits == LIMIT) begin
                ns = 1'b1;
                m_waits = 0;
            end
        end
        if (acc) q.push_back('{a: aux_addr, d: aux_data});
        m_stall = ns;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        @(negedge clk);
        wb_we = we; wb_addr = wa; wb_data = wd;
        aux_valid = av; aux_addr = aa; aux_data = ad;
        #1;
        check_model();
    endtask

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        drive(we, wa, wd, av, aa, ad);
        model_step();
    endtask

    initial begin
        reset = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1;
        aux_valid = 1'b0; aux_addr = 5'd0; aux_data = 32'd0;
        model_reset();
        #3;
        chk("rst_grf_we",    {31'd0, grf_we},      32'd0);
        chk("rst_aux_ready", {31'd0, aux_ready},   32'd1);
        chk("rst_pending",   {30'd0, pending_cnt}, 32'd0);
        chk("rst_stall",     {31'd0, stall_wb},    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // WB write with an empty queue goes straight through.
        cycle(1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 32'd0);
        chk("s1_we",    {31'd0, grf_we}, 32'd1);
        chk("s1_addr",  {27'd0, grf_addr}, 32'd8);
        chk("s1_data",  grf_data, 32'h12345678);
        chk("s1_stall", {31'd0, stall_wb}, 32'd0);

        // Aux entry drains the cycle after its push.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hAAAA0000);
        chk("s2_nobypass", {31'd0, grf_we}, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("s2_we",   {31'd0, grf_we}, 32'd1);
        chk("s2_addr", {27'd0, grf_addr}, 32'd3);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("s2_pending", {30'd0, pending_cnt}, 32'd0);

        // Starvation: WB wins four cycles, then one stall cycle drains the aux entry.
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd5, 32'h55);
        for (int i = 0; i < LIMIT; i++) begin
            cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
            chk("s3_wb_addr", {27'd0, grf_addr}, 32'd9);
        end
        cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        chk("s3_stall",     {31'd0, stall_wb}, 32'd1);
        chk("s3_aux_addr",  {27'd0, grf_addr}, 32'd5);
        cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        chk("s3_wb_again",  {27'd0, grf_addr}, 32'd9);
        chk("s3_stall_off", {31'd0, stall_wb}, 32'd0);

        // Full queue: a third entry waits until the first pop frees a slot.
        cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd6, 32'h66);
        cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd7, 32'h77);
        cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hBB);
        chk("s4_pending", {30'd0, pending_cnt}, 32'd2);
        chk("s4_ready",   {31'd0, aux_ready},   32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hBB);
        for (int i = 0; i < 12; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("s4_drained", {30'd0, pending_cnt}, 32'd0);

        // Address-0 aux entry pops without writing.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("s5_we", {31'd0, grf_we}, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("s5_pending", {30'd0, pending_cnt}, 32'd0);

        // Asynchronous reset during a stall with a full queue discards both entries.
        cycle(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
        cycle(1'b1, 5'd12, 32'hC0, 1'b1, 5'd14, 32'hE0);
        for (int i = 0; i < LIMIT - 1; i++) cycle(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0);
        chk("s6_in_stall", {31'd0, stall_wb},    32'd1);
        chk("s6_full",     {30'd0, pending_cnt}, 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("s6_stall",   {31'd0, stall_wb},    32'd0);
        chk("s6_pending", {30'd0, pending_cnt}, 32'd0);
        chk("s6_we",      {31'd0, grf_we},      32'd0);
        chk("s6_ready",   {31'd0, aux_ready},   32'd1);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            chk("s6_no_write", {31'd0, grf_we}, 32'd0);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
